// File: rtl/sweep_fade_pwm_pkg.sv
// Shared constants and FSM encoding for the sweep/fade PWM slice.
// The upstream sweep stage imports these same definitions.
package sweep_fade_pwm_pkg;

  localparam int unsigned DEF_WIDTH      = 4;
  localparam int unsigned DEF_LEVEL_BITS = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSync = 2'd1,
    StRun  = 2'd2
  } fade_state_e;

endpackage

// File: rtl/sweep_fade_pwm_channel.sv
// One fade channel: brightness level with decay, period-aligned shadow copy,
// and the registered duty comparator.
module sweep_fade_channel #(
  parameter int unsigned LEVEL_BITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  mask_i,
  input  logic                  decay_i,
  input  logic                  load_i,
  input  logic [LEVEL_BITS-1:0] cnt_i,
  output logic                  pwm_o,
  output logic [LEVEL_BITS-1:0] level_o
);

  logic [LEVEL_BITS-1:0] level_q;
  logic [LEVEL_BITS-1:0] shadow_q;
  logic                  pwm_q;

  // Mask beats decay; decay saturates at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      level_q <= '0;
    end else if (mask_i) begin
      level_q <= '1;
    end else if (decay_i && (level_q != '0)) begin
      level_q <= level_q - LEVEL_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      if (load_i) begin
        shadow_q <= level_q;
      end
      pwm_q <= (shadow_q > cnt_i);
    end
  end

  assign pwm_o   = pwm_q;
  assign level_o = level_q;

endmodule

// File: rtl/sweep_fade_pwm.sv
// Multi-channel fade PWM: shared FSM, period counter and decay edge detector
// driving WIDTH fade channels.
module sweep_fade_pwm
  import sweep_fade_pwm_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned LEVEL_BITS = DEF_LEVEL_BITS
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  logic [WIDTH-1:0]            mask_i,
  input  logic                        decay_tick_i,
  output logic [WIDTH-1:0]            pwm_o,
  output logic [WIDTH*LEVEL_BITS-1:0] level_o
);

  localparam logic [LEVEL_BITS-1:0] CNT_MAX = '1;

  fade_state_e           state_q, state_d;
  logic [LEVEL_BITS-1:0] cnt_q;
  logic                  tick_q;
  logic                  active;
  logic                  running;
  logic                  decay_pulse;
  logic                  shadow_load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StSync;
        StSync:  state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Gating with en_i makes a low enable clear every register on the same edge
  // that takes the FSM back to StIdle.
  always_comb begin
    active  = 1'b0;
    running = 1'b0;
    if (en_i) begin
      active  = (state_q == StSync) || (state_q == StRun);
      running = (state_q == StRun);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !running) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + LEVEL_BITS'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !active) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= decay_tick_i;
    end
  end

  assign decay_pulse = decay_tick_i & ~tick_q;
  assign shadow_load = running && (cnt_q == CNT_MAX);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sweep_fade_channel #(
      .LEVEL_BITS(LEVEL_BITS)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (!active),
      .mask_i  (mask_i[i]),
      .decay_i (decay_pulse),
      .load_i  (shadow_load),
      .cnt_i   (cnt_q),
      .pwm_o   (pwm_o[i]),
      .level_o (level_o[i*LEVEL_BITS +: LEVEL_BITS])
    );
  end

endmodule

// File: tb/tb_sweep_fade_pwm.sv
// Directed bench for sweep_fade_pwm at WIDTH=4, LEVEL_BITS=3.
module tb_sweep_fade_pwm;
  import sweep_fade_pwm_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned LB = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic [W-1:0]  mask;
  logic          tick;
  logic [W-1:0]  pwm;
  logic [W*LB-1:0] level;

  int unsigned total;
  int unsigned bad;

  sweep_fade_pwm #(
    .WIDTH      (W),
    .LEVEL_BITS (LB)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .mask_i       (mask),
    .decay_tick_i (tick),
    .pwm_o        (pwm),
    .level_o      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          en;
    logic [W-1:0]  mask;
    logic          tick;
    logic [W*LB-1:0] exp_level;
    logic [W-1:0]  exp_pwm;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] lvl(input int unsigned ch);
    return level[ch*LB +: LB];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; mask = '0; tick = 1'b0;

    // Reset, enable, then channel 0 held at full level.
    for (int i = 0; i < 20; i++) begin
      tbl[i].rst       = 1'b0;
      tbl[i].en        = 1'b1;
      tbl[i].mask      = (i >= 3 && i <= 18) ? 4'b0001 : 4'b0000;
      tbl[i].tick      = 1'b0;
      tbl[i].exp_level = (i >= 3) ? 12'h007 : 12'h000;
      tbl[i].exp_pwm   = ((i >= 11 && i <= 17) || i == 19) ? 4'b0001 : 4'b0000;
    end
    tbl[0].rst = 1'b1;
    tbl[0].en  = 1'b0;

    for (int i = 0; i < 20; i++) begin
      rst  = tbl[i].rst;
      en   = tbl[i].en;
      mask = tbl[i].mask;
      tick = tbl[i].tick;
      step();
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].exp_level));
      chk($sformatf("tbl%0d_pwm", i), 32'(pwm), 32'(tbl[i].exp_pwm));
      if (i == 1) chk("tbl_state_sync", 32'(dut.state_q), 32'(StSync));
      if (i == 2) chk("tbl_state_run", 32'(dut.state_q), 32'(StRun));
    end

    // Decay: tick held 3 cycles per edge, one step per rising edge, floor at 0.
    for (int e = 1; e <= 8; e++) begin
      tick = 1'b1;
      for (int h = 0; h < 3; h++) begin
        step();
        chk($sformatf("decay%0d_hold%0d", e, h), 32'(lvl(0)), (e < 7) ? 32'(7 - e) : 32'd0);
      end
      tick = 1'b0;
      step();
      chk($sformatf("decay%0d_low", e), 32'(lvl(0)), (e < 7) ? 32'(7 - e) : 32'd0);
    end
    for (int c = 0; c < 10; c++) step();
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("zero_level_pwm%0d", c), 32'(pwm), 32'd0);
      step();
    end
    chk("zero_level_all", 32'(level), 32'd0);

    // Collision: mask wins over a simultaneous decay pulse.
    mask = 4'b0010;
    step();
    chk("coll_set", 32'(level), 32'h038);
    mask = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
    chk("coll_pre", 32'(lvl(1)), 32'd3);
    tick = 1'b1; mask = 4'b0010;
    step();
    chk("coll_win", 32'(lvl(1)), 32'd7);
    tick = 1'b0; mask = 4'b0000;
    step();
    chk("coll_hold", 32'(lvl(1)), 32'd7);

    // Disable mid-run clears everything on the next edge.
    en = 1'b0;
    step();
    chk("dis_level", 32'(level), 32'd0);
    chk("dis_pwm", 32'(pwm), 32'd0);
    chk("dis_cnt", 32'(dut.cnt_q), 32'd0);
    chk("dis_state", 32'(dut.state_q), 32'(StIdle));

    // Re-enable through StSync, then a mid-period level change on channel 2.
    en = 1'b1;
    step();
    chk("reen_state_sync", 32'(dut.state_q), 32'(StSync));
    chk("reen_level", 32'(level), 32'd0);
    mask = 4'b0100;
    step();
    chk("reen_state_run", 32'(dut.state_q), 32'(StRun));
    chk("reen_latency", 32'(level), 32'h1C0);
    mask = 4'b0000;
    for (int k = 3; k <= 26; k++) begin
      logic exp_b;
      int unsigned exp_l;
      tick = (k == 12 || k == 14);
      step();
      exp_b = (k >= 11 && k <= 17) || (k >= 19 && k <= 23);
      exp_l = (k < 12) ? 7 : ((k < 14) ? 6 : 5);
      chk($sformatf("glitch_pwm_k%0d", k), 32'(pwm), 32'({1'b0, exp_b, 2'b00}));
      chk($sformatf("glitch_lvl_k%0d", k), 32'(lvl(2)), 32'(exp_l));
    end
    tick = 1'b0;

    // Reset mid-period overrides enable; restart goes through StSync.
    rst = 1'b1;
    step();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(StIdle));
    rst = 1'b0;
    step();
    chk("rst_rel_sync", 32'(dut.state_q), 32'(StSync));
    step();
    chk("rst_rel_run", 32'(dut.state_q), 32'(StRun));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sweep_fade_pwm.md
SWEEP_FADE_PWM -- requirements
Module: sweep_fade_pwm

Interface
REQ-001 Parameter WIDTH, default 4, channel count; SHALL match the WIDTH of the upstream sweep mask.
REQ-002 Parameter LEVEL_BITS, default 4, brightness resolution; MAX = 2^LEVEL_BITS-1.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 en_i  input  1  block enable; low holds the block cleared.
REQ-006 mask_i  input  WIDTH  sweep mask from upstream; bit i high = channel i lit.
REQ-007 decay_tick_i  input  1  decay timebase, level signal; only its rising edge is used.
REQ-008 pwm_o  output  WIDTH  registered PWM drive, one bit per channel.
REQ-009 level_o  output  WIDTH*LEVEL_BITS  current channel levels, channel i at bits [i*LEVEL_BITS +: LEVEL_BITS].

Function
REQ-010 FSM states SHALL be StIdle, StSync, StRun.
REQ-011 StIdle -> StSync when en_i high; StSync -> StRun after exactly one cycle; any state -> StIdle in the cycle after en_i samples low.
REQ-012 In StIdle: pwm counter, levels, shadows, pwm_o, and the edge register SHALL all be 0.
REQ-013 In StSync: pwm counter = 0 and shadows = 0; levels SHALL update per REQ-015..017.
REQ-014 In StRun: the LEVEL_BITS pwm counter SHALL increment every cycle and wrap MAX -> 0; period = 2^LEVEL_BITS cycles.
REQ-015 Decay pulse = decay_tick_i & ~decay_tick_q, where decay_tick_q is decay_tick_i registered; a held-high tick SHALL yield one pulse.
REQ-016 Per channel, per cycle in StSync/StRun: if mask_i[i] then level <= MAX; else if decay pulse and level > 0 then level <= level-1; else hold.
REQ-017 Mask set and decay pulse together: mask SHALL win (level = MAX); decrement SHALL saturate at 0, with no wrap.
REQ-018 Shadow[i] <= level[i] SHALL load only in the StRun cycle where counter == MAX, so duty changes only at period boundaries (glitch-free).
REQ-019 pwm_o[i] <= (shadow[i] > counter), registered; duty = shadow/2^LEVEL_BITS; level 0 SHALL give constant 0.
REQ-020 level_o SHALL show the level registers directly (no extra latency).
REQ-021 Latency: mask_i high at cycle n gives level_o = MAX at n+1; pwm_o reflects it starting one cycle after the next shadow load.

Reset
REQ-022 With rst_i high at a clock edge, the FSM SHALL be StIdle and all registers/outputs 0, overriding en_i.
REQ-023 Reset mid-period or mid-decay SHALL discard all state; after release, operation SHALL restart via StSync.

Structure
REQ-024 The shared package/include SHALL hold the FSM state encodings and the default WIDTH/LEVEL_BITS constants, and the upstream sweep stage SHALL use the same ones.
REQ-025 One sub-module, sweep_fade_channel (level register, shadow, comparator), SHALL be instantiated WIDTH times; the counter, FSM and edge detector are shared in the top.

Verification (WIDTH=4, LEVEL_BITS=3, MAX=7)
REQ-026 Reset/enable: rst_i 1 then 0, en_i 1 -> StSync for 1 cycle, then StRun; pwm_o=0, level_o=0 until the first mask bit.
REQ-027 Full duty: mask_i=4'b0001 held -> level0=7; after the shadow load, pwm_o[0] high 7 of every 8 cycles; other channels 0.
REQ-028 Decay: mask_i 0001->0000, then 7 decay rising edges (tick held 3 cycles each) -> level0 steps 7,6,...,0 once per edge; an 8th edge leaves level0=0.
REQ-029 Collision: mask_i[1] rises in the same cycle as a decay pulse while level1=3 -> level1=7 the next cycle.
REQ-030 Glitch-free: level changes mid-period -> pwm_o pattern for the rest of that period is unchanged; the new duty starts after counter==7.
REQ-031 Disable mid-run: en_i 0 while levels are nonzero -> next cycle all levels, pwm_o and counter are 0; re-enable passes through StSync.
